axi_sub_rd_ctrl: RTL and testbench
==================================

# axi_sub_rd_ctrl

AXI read-channel front end for a subordinate. It accepts one AR transaction at a time and expands it into per-beat requests (INCR/FIXED/WRAP) on the read port of the subordinate read/write arbiter. It captures `r_rdata`/`r_err` a fixed `C_LAT` cycles after each granted beat and buffers them in a credit-protected response FIFO that drives the AXI R channel. The block sits directly upstream of the arbiter, on its read side.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width. `BC = DW/8`, `BW = $clog2(BC)` (derived).
- `UW`, 32: user width.
- `IW`, 1: ID width.
- `C_LAT`, 0: component latency from granted beat to `r_rdata`/`r_err` valid. Constant.
- `DEPTH`, `C_LAT+2`: response FIFO entries. Must be ≥ `C_LAT+2`.

Ports:
- `clk` in 1: clock. The only clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_araddr` in AW, `s_arburst` in 2, `s_arsize` in 3, `s_arlen` in 8, `s_aruser` in UW, `s_arid` in IW: AR payload.
- `s_arvalid` in 1 / `s_arready` out 1: AR handshake.
- `s_rdata` out DW, `s_rresp` out 2, `s_rid` out IW, `s_ruser` out UW, `s_rlast` out 1: R payload.
- `s_rvalid` out 1 / `s_rready` in 1: R handshake.
- `r_dv` out 1: beat request to the arbiter.
- `r_addr` out AW, `r_user` out UW, `r_id` out IW: beat payload.
- `r_last` out 1: asserted with the final beat of a burst.
- `r_hld` in 1: beat not granted this cycle.
- `r_err` in 1: read error, valid `C_LAT` cycles after grant.
- `r_rdata` in DW: read data, valid `C_LAT` cycles after grant.

## Operation
State machine:
- **IDLE:** `s_arready`=1.
  - On `s_arvalid && s_arready`: latch addr, burst, size, len, id, user; set beat counter to `s_arlen`; go to BURST.
- **BURST:** `s_arready`=0.
  - `r_dv` = credit available, where credit available = (fifo_count + inflight < DEPTH).
  - A beat is *granted* when `r_dv && !r_hld`.
  - On grant: advance the address and decrement the beat counter.
  - When the granted beat is last, return to IDLE on the next cycle.

Beat payload and address arithmetic:
- `r_last` = (beat counter == 0).
- `r_id` and `r_user` are the latched AR values for the whole burst.
- Beat size is `2**size` bytes.
- INCR: addr += beat size, full AW-bit add, wraps at 2^AW.
- FIXED: addr held.
- WRAP: boundary = (len+1)·size bytes. Lower = addr & ~(boundary−1). The next address wraps to lower when it reaches lower+boundary. Legal len for WRAP is 1, 3, 7, 15; any other len is treated as INCR.
- Reserved burst `2'b11`: behaves as FIXED, and every beat gets `s_rresp`=SLVERR.
- `s_arsize > BW`: beats are still issued, and every beat gets SLVERR.

Response path:
- A `C_LAT`-deep shift pipe carries {valid, last, id, user, force_err} per granted beat.
- At pipe exit (same cycle as the grant when `C_LAT`=0), the FIFO pushes {`r_rdata`, resp, last, id, user}.
- resp = SLVERR (`2'b10`) if `r_err` or force_err, else OKAY (`2'b00`).
- inflight = number of valid pipe stages.
- The R channel is driven by the FIFO head. Pop on `s_rvalid && s_rready`.
- A same-cycle pop does not free credit until the next cycle.
- The FIFO can never overflow; a push while full is an assertion failure.
- R payload is held stable while `s_rvalid && !s_rready`.

## Timing
Reset: all state clears on the cycle `rst` is sampled high. Outputs next cycle:
- `s_arready`=1, `s_rvalid`=0.
- `r_dv`=0, `r_last`=0.
- `r_addr`, `r_id`, `r_user`, `s_rdata`, `s_rresp`, `s_rid`, `s_ruser`, `s_rlast` = 0.
- Reset mid-burst discards in-flight beats and FIFO contents. No R beats are emitted for the aborted burst.

Latencies and throughput:
- AR accepted at T: first `r_dv` at T+1.
- Next AR accepted no earlier than the cycle after the last beat grant.
- Beat granted at t: data enters the FIFO at t+`C_LAT`, and `s_rvalid` for that beat is seen at t+`C_LAT`+1.
- Sustained throughput is 1 beat/cycle with `s_rready`=1 and `r_hld`=0.

Simultaneous events and stalls:
- `r_hld` stalls the address and counter; `r_dv` stays asserted.
- Backpressure on `s_rready` throttles `r_dv` via credit.
- Simultaneous push and pop: count is unchanged.

## Test plan
- **Single beat.** `C_LAT`=0, AR addr=0x100, INCR, len=0, size=2, id=1. Expect: `r_dv` one cycle with `r_last`=1, `r_addr`=0x100; one R beat `s_rlast`=1, `s_rid`=1, OKAY, data = `r_rdata` sampled at the grant.
- **INCR throughput.** `C_LAT`=2, INCR len=3 from 0x10, size=2. Expect `r_addr` 0x10, 0x14, 0x18, 0x1C on consecutive cycles; R beats on consecutive cycles starting 3 cycles after the first grant; `s_rlast` only on beat 4.
- **WRAP.** addr=0x38, len=3, size=2. Expect addresses 0x38, 0x3C, 0x30, 0x34. FIXED len=2 at 0x40: three beats all at 0x40.
- **Backpressure.** `C_LAT`=1, `DEPTH`=3, INCR len=7, `s_rready`=0. Expect exactly 3 grants then `r_dv`=0. Releasing `s_rready` drains in order with no loss or duplication.
- **Errors and hold.** Assert `r_err` on beat 2 of 4: only that beat gets `s_rresp`=`2'b10`. `arburst`=`2'b11`: all beats SLVERR. Hold `r_hld`=1 for 5 cycles mid-burst: `r_addr` stable, no beat skipped.
- **Reset mid-burst.** Assert `rst` during beat 2 of 8. Expect next cycle `s_rvalid`=0, `r_dv`=0, `s_arready`=1. A following AR completes normally with correct IDs.

Source files
------------

// File: rtl/axi_sub_rd_ctrl.sv
// AXI read-channel front end: expands one AR burst into per-beat arbiter requests
// and returns the beat data through a credit-protected response FIFO on the R channel.
module axi_sub_rd_ctrl #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned UW    = 32,
  parameter int unsigned IW    = 1,
  parameter int unsigned C_LAT = 0,
  parameter int unsigned DEPTH = C_LAT + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] s_araddr,
  input  logic [1:0]    s_arburst,
  input  logic [2:0]    s_arsize,
  input  logic [7:0]    s_arlen,
  input  logic [UW-1:0] s_aruser,
  input  logic [IW-1:0] s_arid,
  input  logic          s_arvalid,
  output logic          s_arready,
  output logic [DW-1:0] s_rdata,
  output logic [1:0]    s_rresp,
  output logic [IW-1:0] s_rid,
  output logic [UW-1:0] s_ruser,
  output logic          s_rlast,
  output logic          s_rvalid,
  input  logic          s_rready,
  output logic          r_dv,
  output logic [AW-1:0] r_addr,
  output logic [UW-1:0] r_user,
  output logic [IW-1:0] r_id,
  output logic          r_last,
  input  logic          r_hld,
  input  logic          r_err,
  input  logic [DW-1:0] r_rdata
);

  localparam int unsigned BC = DW / 8;
  localparam int unsigned BW = $clog2(BC);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(2 * DEPTH + 1);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    burst_q, burst_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [UW-1:0] user_q, user_d;
  logic          ferr_q, ferr_d;

  logic [CW-1:0] count_q;
  logic [CW-1:0] inflight_c;
  logic          grant_c;

  logic [AW-1:0] bsize_c, incr_c, bound_c, lower_c, next_addr_c;
  logic          wrap_ok_c;

  assign s_arready = (state_q == ST_IDLE);
  assign r_dv      = (state_q == ST_BURST) && ((count_q + inflight_c) < CW'(DEPTH));
  assign grant_c   = r_dv && !r_hld;
  assign r_addr    = addr_q;
  assign r_id      = id_q;
  assign r_user    = user_q;
  assign r_last    = (state_q == ST_BURST) && (cnt_q == 8'd0);

  // Next beat address; a WRAP with an illegal length falls back to INCR
  always_comb begin
    bsize_c     = AW'(1) << size_q;
    incr_c      = addr_q + bsize_c;
    bound_c     = (AW'(len_q) + AW'(1)) << size_q;
    lower_c     = addr_q & ~(bound_c - AW'(1));
    wrap_ok_c   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    next_addr_c = addr_q;
    case (burst_q)
      BURST_INCR: next_addr_c = incr_c;
      BURST_WRAP: next_addr_c = (wrap_ok_c && (incr_c == lower_c + bound_c)) ? lower_c : incr_c;
      default:    next_addr_c = addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    size_d  = size_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    user_d  = user_q;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        if (s_arvalid) begin
          addr_d  = s_araddr;
          burst_d = s_arburst;
          size_d  = s_arsize;
          len_d   = s_arlen;
          cnt_d   = s_arlen;
          id_d    = s_arid;
          user_d  = s_aruser;
          ferr_d  = (s_arburst == BURST_RSVD) || (s_arsize > 3'(BW));
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (grant_c) begin
          addr_d = next_addr_c;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      burst_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      user_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      size_q  <= size_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      user_q  <= user_d;
      ferr_q  <= ferr_d;
    end
  end

  // Beat tracking pipe that lines up with the component's read latency
  logic          exit_v_c, exit_last_c, exit_ferr_c;
  logic [IW-1:0] exit_id_c;
  logic [UW-1:0] exit_user_c;

  generate
    if (C_LAT == 0) begin : g_nopipe
      assign exit_v_c    = grant_c;
      assign exit_last_c = r_last;
      assign exit_ferr_c = ferr_q;
      assign exit_id_c   = id_q;
      assign exit_user_c = user_q;
      assign inflight_c  = '0;
    end else begin : g_pipe
      logic [C_LAT-1:0] pv_q, pl_q, pe_q;
      logic [IW-1:0]    pid_q [C_LAT];
      logic [UW-1:0]    pu_q  [C_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          pv_q <= '0;
          pl_q <= '0;
          pe_q <= '0;
          for (int unsigned i = 0; i < C_LAT; i++) begin
            pid_q[i] <= '0;
            pu_q[i]  <= '0;
          end
        end else begin
          pv_q[0]  <= grant_c;
          pl_q[0]  <= r_last;
          pe_q[0]  <= ferr_q;
          pid_q[0] <= id_q;
          pu_q[0]  <= user_q;
          for (int unsigned i = 1; i < C_LAT; i++) begin
            pv_q[i]  <= pv_q[i-1];
            pl_q[i]  <= pl_q[i-1];
            pe_q[i]  <= pe_q[i-1];
            pid_q[i] <= pid_q[i-1];
            pu_q[i]  <= pu_q[i-1];
          end
        end
      end

      always_comb begin
        inflight_c = '0;
        for (int unsigned i = 0; i < C_LAT; i++) inflight_c = inflight_c + CW'(pv_q[i]);
      end

      assign exit_v_c    = pv_q[C_LAT-1];
      assign exit_last_c = pl_q[C_LAT-1];
      assign exit_ferr_c = pe_q[C_LAT-1];
      assign exit_id_c   = pid_q[C_LAT-1];
      assign exit_user_c = pu_q[C_LAT-1];
    end
  endgenerate

  // Response FIFO; credit on r_dv guarantees a free slot for every beat in flight
  logic [DW-1:0] fd_q [DEPTH];
  logic [1:0]    fr_q [DEPTH];
  logic          fl_q [DEPTH];
  logic [IW-1:0] fi_q [DEPTH];
  logic [UW-1:0] fu_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic          push_c, pop_c;

  assign push_c = exit_v_c;
  assign pop_c  = s_rvalid && s_rready;

  always_ff @(posedge clk) begin
    if (push_c) begin
      fd_q[wr_q] <= r_rdata;
      fr_q[wr_q] <= (r_err || exit_ferr_c) ? RESP_SLVERR : RESP_OKAY;
      fl_q[wr_q] <= exit_last_c;
      fi_q[wr_q] <= exit_id_c;
      fu_q[wr_q] <= exit_user_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop_c)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(push_c && (count_q == CW'(DEPTH))));
  end

  assign s_rvalid = (count_q != '0);
  assign s_rdata  = s_rvalid ? fd_q[rd_q] : '0;
  assign s_rresp  = s_rvalid ? fr_q[rd_q] : '0;
  assign s_rlast  = s_rvalid ? fl_q[rd_q] : 1'b0;
  assign s_rid    = s_rvalid ? fi_q[rd_q] : '0;
  assign s_ruser  = s_rvalid ? fu_q[rd_q] : '0;

endmodule

// File: tb/tb_axi_sub_rd_ctrl.sv
// Randomized bench for axi_sub_rd_ctrl: a queue-based transaction model predicts beat
// addresses, credit-limited r_dv and the ordered R responses.
module tb_axi_sub_rd_ctrl;

  localparam int unsigned AW = 32, DW = 32, UW = 32, IW = 1;
  localparam int unsigned C_LAT = 1, DEPTH = 3;

  logic          clk, rst;
  logic [AW-1:0] s_araddr;
  logic [1:0]    s_arburst;
  logic [2:0]    s_arsize;
  logic [7:0]    s_arlen;
  logic [UW-1:0] s_aruser;
  logic [IW-1:0] s_arid;
  logic          s_arvalid, s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic [IW-1:0] s_rid;
  logic [UW-1:0] s_ruser;
  logic          s_rlast, s_rvalid, s_rready;
  logic          r_dv, r_last, r_hld, r_err;
  logic [AW-1:0] r_addr;
  logic [UW-1:0] r_user;
  logic [IW-1:0] r_id;
  logic [DW-1:0] r_rdata;

  axi_sub_rd_ctrl #(.AW(AW), .DW(DW), .UW(UW), .IW(IW), .C_LAT(C_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arburst(s_arburst), .s_arsize(s_arsize), .s_arlen(s_arlen),
    .s_aruser(s_aruser), .s_arid(s_arid), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_ruser(s_ruser),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .r_dv(r_dv), .r_addr(r_addr), .r_user(r_user), .r_id(r_id), .r_last(r_last),
    .r_hld(r_hld), .r_err(r_err), .r_rdata(r_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic last; logic [IW-1:0] id; logic [31:0] user; logic ferr; } req_t;
  typedef struct { int due; logic last; logic [IW-1:0] id; logic [31:0] user; logic ferr; } pend_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [IW-1:0] id; logic [31:0] user; } rsp_t;

  req_t  exp_req[$];
  pend_t pend[$];
  rsp_t  exp_r[$];
  logic [31:0] got_addrs[$];
  int          got_cyc[$];
  logic [1:0]  got_resp[$];

  int checks = 0, failures = 0;
  int cyc = 0, grants = 0, pops = 0, err_pops = 0;
  int rr_mode = 1;
  bit hld_rand = 0, err_rand = 0, force_hld = 0, err_force = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Address of beat i computed directly from the burst rules
  function automatic logic [31:0] beat_addr(logic [31:0] a, logic [1:0] b, logic [2:0] sz,
                                            logic [7:0] len, int i);
    longint unsigned bs, bnd, lo, st, ii;
    bs = 64'd1 << sz;
    st = 64'(a);
    ii = 64'(i);
    if (b == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      bnd = (64'(len) + 64'd1) * bs;
      lo  = st - (st % bnd);
      return 32'(lo + ((st - lo + ii * bs) % bnd));
    end else if (b == 2'b01 || b == 2'b10) begin
      return 32'(st + ii * bs);
    end
    return a;
  endfunction

  // Stimulus for the read port and R channel, re-randomized every cycle
  initial begin
    forever begin
      @(posedge clk); #1;
      r_rdata  = $urandom;
      r_err    = err_force || (err_rand && ($urandom_range(5) == 0));
      r_hld    = force_hld || (hld_rand && ($urandom_range(3) == 0));
      s_rready = (rr_mode == 0) ? 1'b0 : (rr_mode == 1) ? 1'b1 : 1'($urandom_range(1));
    end
  end

  // Monitor and reference model, evaluated mid-cycle
  logic        prev_hold, prev_rstall, prev_rlast;
  logic [31:0] prev_addr, prev_rdata;
  always @(negedge clk) begin
    req_t  q;
    pend_t p;
    rsp_t  r;
    int    outstanding;
    cyc++;
    if (rst) begin
      exp_req.delete(); pend.delete(); exp_r.delete();
      prev_hold = 0; prev_rstall = 0;
    end else begin
      outstanding = pend.size() + exp_r.size();
      check("r_dv", r_dv, (exp_req.size() > 0) && (outstanding < DEPTH));
      check("s_arready", s_arready, exp_req.size() == 0);
      check("s_rvalid", s_rvalid, exp_r.size() > 0);
      if (prev_hold) check("hold_addr", r_addr, prev_addr);
      if (prev_rstall) begin
        check("r_stable_data", s_rdata, prev_rdata);
        check("r_stable_last", s_rlast, prev_rlast);
      end
      if (s_rvalid && s_rready && exp_r.size() > 0) begin
        r = exp_r.pop_front();
        check("r_data", s_rdata, r.data);
        check("r_resp", s_rresp, r.resp);
        check("r_last", s_rlast, r.last);
        check("r_id", s_rid, r.id);
        check("r_user", s_ruser, r.user);
        pops++;
        if (s_rresp == 2'b10) err_pops++;
        got_resp.push_back(s_rresp);
      end
      if (r_dv && !r_hld) begin
        if (exp_req.size() == 0) check("spurious_grant", 1, 0);
        else begin
          q = exp_req.pop_front();
          check("beat_addr", r_addr, q.addr);
          check("beat_last", r_last, q.last);
          check("beat_id", r_id, q.id);
          check("beat_user", r_user, q.user);
          pend.push_back('{due: cyc + C_LAT, last: q.last, id: q.id, user: q.user, ferr: q.ferr});
          grants++;
          got_addrs.push_back(r_addr);
          got_cyc.push_back(cyc);
        end
      end
      while (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        exp_r.push_back('{data: r_rdata, resp: (r_err || p.ferr) ? 2'b10 : 2'b00,
                          last: p.last, id: p.id, user: p.user});
      end
      if (s_arvalid && s_arready) begin
        for (int i = 0; i <= int'(s_arlen); i++)
          exp_req.push_back('{addr: beat_addr(s_araddr, s_arburst, s_arsize, s_arlen, i),
                              last: (i == int'(s_arlen)), id: s_arid, user: s_aruser,
                              ferr: (s_arburst == 2'b11) || (s_arsize > 3'd2)});
      end
      prev_hold   = r_dv && r_hld;
      prev_addr   = r_addr;
      prev_rstall = s_rvalid && !s_rready;
      prev_rdata  = s_rdata;
      prev_rlast  = s_rlast;
    end
  end

  task automatic issue_ar(input logic [31:0] a, input logic [1:0] b, input logic [2:0] sz,
                          input logic [7:0] len, input logic [IW-1:0] id, input logic [31:0] u);
    bit ok = 0;
    @(posedge clk); #1;
    s_araddr = a; s_arburst = b; s_arsize = sz; s_arlen = len; s_arid = id; s_aruser = u;
    s_arvalid = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_arready) begin ok = 1; break; end
    end
    if (!ok) check("ar_timeout", 0, 1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 8000; n++) begin
      @(negedge clk); #1;
      if (exp_req.size() == 0 && pend.size() == 0 && exp_r.size() == 0 && !s_rvalid) begin
        ok = 1; break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic clear_got();
    got_addrs.delete(); got_cyc.delete(); got_resp.delete();
  endtask

  task automatic check_addrs(input string tag, input logic [31:0] exp_q[$]);
    check({tag, "_count"}, got_addrs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_addrs.size(); i++) check(tag, got_addrs[i], exp_q[i]);
  endtask

  initial begin
    logic [31:0] ea[$];
    logic [31:0] a, msk;
    logic [1:0]  b;
    logic [2:0]  sz;
    logic [7:0]  len;
    int p0, e0, g0, nbeats;
    bit ok;

    rst = 1'b1; s_arvalid = 0; s_araddr = 0; s_arburst = 0; s_arsize = 0; s_arlen = 0;
    s_arid = 0; s_aruser = 0; s_rready = 1; r_hld = 0; r_err = 0; r_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_arready", s_arready, 1);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_r_dv", r_dv, 0);
    check("rst_r_last", r_last, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_r_id_user", {r_id, r_user}, 0);
    check("rst_r_payload", {s_rdata, s_rresp, s_rid, s_ruser, s_rlast}, 0);

    // Single beat
    clear_got(); p0 = pops;
    issue_ar(32'h100, 2'b01, 3'd2, 8'd0, 1'b1, 32'h0000_ABCD);
    wait_idle();
    ea = {32'h100}; check_addrs("single_addr", ea);
    check("single_pops", pops - p0, 1);

    // INCR at full rate
    clear_got();
    issue_ar(32'h10, 2'b01, 3'd2, 8'd3, 1'b0, 32'h1);
    wait_idle();
    ea = {32'h10, 32'h14, 32'h18, 32'h1C}; check_addrs("incr_addr", ea);
    if (got_cyc.size() == 4) check("incr_tput", got_cyc[3] - got_cyc[0], 3);
    else check("incr_tput_beats", got_cyc.size(), 4);

    // WRAP and FIXED
    clear_got();
    issue_ar(32'h38, 2'b10, 3'd2, 8'd3, 1'b1, 32'h2);
    wait_idle();
    ea = {32'h38, 32'h3C, 32'h30, 32'h34}; check_addrs("wrap_addr", ea);
    clear_got();
    issue_ar(32'h40, 2'b00, 3'd2, 8'd2, 1'b0, 32'h3);
    wait_idle();
    ea = {32'h40, 32'h40, 32'h40}; check_addrs("fixed_addr", ea);

    // Reserved burst and oversize beats are all SLVERR
    e0 = err_pops;
    issue_ar(32'h50, 2'b11, 3'd2, 8'd3, 1'b1, 32'h4);
    wait_idle();
    check("rsvd_slverr", err_pops - e0, 4);
    clear_got(); e0 = err_pops;
    issue_ar(32'h80, 2'b01, 3'd3, 8'd1, 1'b0, 32'h5);
    wait_idle();
    ea = {32'h80, 32'h88}; check_addrs("oversize_addr", ea);
    check("oversize_slverr", err_pops - e0, 2);

    // r_err on beat 2 of 4 only
    clear_got();
    issue_ar(32'h90, 2'b01, 3'd2, 8'd3, 1'b0, 32'h6);
    @(posedge clk); #2 err_force = 1;
    @(posedge clk); #2 err_force = 0;
    wait_idle();
    check("err_beats", got_resp.size(), 4);
    if (got_resp.size() == 4) check("err_resp_seq", {got_resp[0], got_resp[1], got_resp[2], got_resp[3]}, 8'b00_10_00_00);

    // Randomized bursts with random backpressure, holds and errors
    rr_mode = 2; hld_rand = 1; err_rand = 1; p0 = pops; nbeats = 0;
    for (int t = 0; t < 40; t++) begin
      b  = 2'($urandom_range(3));
      sz = 3'($urandom_range(4));
      if (b == 2'b10 && $urandom_range(3) != 0) len = 8'((2 << $urandom_range(3)) - 1);
      else len = 8'($urandom_range(15));
      msk = 32'hFFFF_FFFF << sz;
      a = $urandom & msk;
      issue_ar(a, b, sz, len, 1'($urandom_range(1)), $urandom);
      nbeats += int'(len) + 1;
    end
    wait_idle();
    check("rand_pops", pops - p0, nbeats);
    rr_mode = 1; hld_rand = 0; err_rand = 0;

    // Credit backpressure
    rr_mode = 0; g0 = grants; p0 = pops;
    issue_ar(32'h300, 2'b01, 3'd2, 8'd7, 1'b1, 32'h7);
    repeat (10) @(negedge clk);
    #1;
    check("bp_grants", grants - g0, DEPTH);
    check("bp_r_dv", r_dv, 0);
    rr_mode = 1;
    wait_idle();
    check("bp_total_grants", grants - g0, 8);
    check("bp_total_pops", pops - p0, 8);

    // Five-cycle hold mid-burst
    clear_got();
    issue_ar(32'h400, 2'b01, 3'd2, 8'd7, 1'b0, 32'h8);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (got_addrs.size() >= 2) begin ok = 1; break; end
    end
    if (!ok) check("hold_start_timeout", 0, 1);
    force_hld = 1;
    repeat (5) @(posedge clk);
    force_hld = 0;
    wait_idle();
    ea.delete();
    for (int i = 0; i < 8; i++) ea.push_back(32'h400 + 32'(4 * i));
    check_addrs("hold_seq", ea);

    // Reset during the second beat of an 8-beat burst
    clear_got();
    issue_ar(32'h500, 2'b01, 3'd2, 8'd7, 1'b0, 32'h9);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (got_addrs.size() >= 1) begin ok = 1; break; end
    end
    if (!ok) check("rst_start_timeout", 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("midrst_rvalid", s_rvalid, 0);
    check("midrst_r_dv", r_dv, 0);
    check("midrst_arready", s_arready, 1);
    p0 = pops; clear_got();
    issue_ar(32'h600, 2'b01, 3'd2, 8'd3, 1'b1, 32'hA);
    wait_idle();
    check("post_rst_pops", pops - p0, 4);
    ea = {32'h600, 32'h604, 32'h608, 32'h60C}; check_addrs("post_rst_addr", ea);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
